// File: rtl/light_schedule_ctrl_pkg.sv
// Shared definitions for the lighting schedule controller: FSM encodings,
// minute-of-day width and the hours/minutes to minute-of-day conversion.
package light_schedule_ctrl_pkg;

    typedef enum logic [1:0] {
        LS_OFF      = 2'b00,
        LS_FADE_IN  = 2'b01,
        LS_ON       = 2'b10,
        LS_FADE_OUT = 2'b11
    } ls_state_t;

    localparam int MOD_W           = 11;
    localparam int MINUTES_PER_DAY = 1440;

    localparam logic [5:0]  MAX_HOUR   = 6'd23;
    localparam logic [5:0]  MAX_MINUTE = 6'd59;
    // Out-of-range pattern held in the time synchronisers after reset so the
    // all-zero reset contents are never mistaken for a real 00:00 sample.
    localparam logic [11:0] TIME_SENTINEL = 12'hFFF;

    function automatic logic [MOD_W-1:0] to_mod(input logic [5:0] hours,
                                                input logic [5:0] minutes);
        logic [MOD_W-1:0] t;
        t = MOD_W'(hours) * MOD_W'(60) + MOD_W'(minutes);
        return (t >= MOD_W'(MINUTES_PER_DAY)) ? t - MOD_W'(MINUTES_PER_DAY) : t;
    endfunction

endpackage

// File: rtl/light_schedule_ctrl_pwm_gen.sv
// PWM generator: free-running counter compared against the brightness level,
// with the top level forced fully on so the LEDs never flicker at max.
module pwm_gen #(
    parameter int PWM_BITS = 8,
    parameter int N_LEDS   = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [PWM_BITS-1:0] i_level,
    output logic [N_LEDS-1:0]   o_leds
);

    localparam logic [PWM_BITS-1:0] MAX_LVL = '1;

    logic [PWM_BITS-1:0] r_cnt;
    logic [N_LEDS-1:0]   r_leds;
    logic                w_on;

    assign w_on = (i_level == MAX_LVL) || (r_cnt < i_level);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_leds <= '0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_leds <= {N_LEDS{w_on}};
        end
    end

    assign o_leds = r_leds;

endmodule

// File: rtl/light_schedule_ctrl.sv
// Lighting schedule controller: resynchronises RTC time, decides the ON window,
// and fades LED brightness in/out with a manual override on top of the schedule.
module light_schedule_ctrl
    import light_schedule_ctrl_pkg::*;
#(
    parameter int N_LEDS        = 16,
    parameter int PWM_BITS      = 8,
    parameter int FADE_STEP_CYC = 390625,
    parameter int ON_HOUR       = 18,
    parameter int ON_MIN        = 0,
    parameter int OFF_HOUR      = 6,
    parameter int OFF_MIN       = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [5:0]          i_hours,
    input  logic [5:0]          i_minutes,
    input  logic                i_override,
    input  logic                i_manual_on,
    output logic [N_LEDS-1:0]   o_leds,
    output logic [PWM_BITS-1:0] o_brightness,
    output logic [1:0]          o_state,
    output logic                o_manual,
    output logic                o_in_window
);

    localparam logic [PWM_BITS-1:0] MAX_LVL   = '1;
    localparam int                  PRESC_W   = (FADE_STEP_CYC > 1) ? $clog2(FADE_STEP_CYC) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(FADE_STEP_CYC - 1);
    localparam logic [MOD_W-1:0]    ON_T      = to_mod(6'(ON_HOUR), 6'(ON_MIN));
    localparam logic [MOD_W-1:0]    OFF_T     = to_mod(6'(OFF_HOUR), 6'(OFF_MIN));

    logic [11:0]         r_sync1, r_sync2, r_cmp;
    logic [MOD_W-1:0]    r_accT;
    logic                r_timeValid;
    logic                r_inWindow;
    logic                r_manual;
    ls_state_t           r_state, w_stateNext;
    logic [PRESC_W-1:0]  r_presc;
    logic [PWM_BITS-1:0] r_bright;

    logic                w_sampleOk, w_accept, w_inWin, w_target;
    logic                w_stepTick, w_inc, w_dec;
    logic [MOD_W-1:0]    w_curT;

    // A sample is only trusted once two consecutive synchronised copies agree.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= TIME_SENTINEL;
            r_sync2 <= TIME_SENTINEL;
            r_cmp   <= TIME_SENTINEL;
        end else begin
            r_sync1 <= {i_hours, i_minutes};
            r_sync2 <= r_sync1;
            r_cmp   <= r_sync2;
        end
    end

    assign w_sampleOk = (r_sync2[11:6] <= MAX_HOUR) && (r_sync2[5:0] <= MAX_MINUTE);
    assign w_accept   = w_sampleOk && (r_sync2 == r_cmp);
    assign w_curT     = w_accept ? to_mod(r_sync2[11:6], r_sync2[5:0]) : r_accT;

    always_comb begin
        w_inWin = 1'b0;
        if (ON_T < OFF_T)
            w_inWin = (w_curT >= ON_T) && (w_curT < OFF_T);
        else if (ON_T > OFF_T)
            w_inWin = (w_curT >= ON_T) || (w_curT < OFF_T);
    end

    // The window stays closed until the first real sample has been accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_accT      <= '0;
            r_timeValid <= 1'b0;
            r_inWindow  <= 1'b0;
            r_manual    <= 1'b0;
        end else begin
            r_accT      <= w_curT;
            r_timeValid <= r_timeValid | w_accept;
            r_inWindow  <= (r_timeValid | w_accept) & w_inWin;
            if (i_override)
                r_manual <= ~r_manual;
        end
    end

    assign w_target = r_manual ? i_manual_on : r_inWindow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= LS_OFF;
        else
            r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            LS_OFF:      if (w_target) w_stateNext = LS_FADE_IN;
            LS_FADE_IN:  if (!w_target) w_stateNext = LS_FADE_OUT;
                         else if (r_bright == MAX_LVL) w_stateNext = LS_ON;
            LS_ON:       if (!w_target) w_stateNext = LS_FADE_OUT;
            LS_FADE_OUT: if (w_target) w_stateNext = LS_FADE_IN;
                         else if (r_bright == '0) w_stateNext = LS_OFF;
            default:     w_stateNext = LS_OFF;
        endcase
    end

    // Steps are suppressed on the cycle the state changes, so a reversal
    // resumes from the current level without a jump.
    always_comb begin
        w_stepTick = (r_presc == PRESC_MAX);
        w_inc      = (r_state == LS_FADE_IN) && (w_stateNext == r_state)
                     && w_stepTick && (r_bright != MAX_LVL);
        w_dec      = (r_state == LS_FADE_OUT) && (w_stateNext == r_state)
                     && w_stepTick && (r_bright != '0);
        o_state    = r_state;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc  <= '0;
            r_bright <= '0;
        end else begin
            if ((w_stateNext != r_state) || w_stepTick
                || (r_state == LS_OFF) || (r_state == LS_ON))
                r_presc <= '0;
            else
                r_presc <= r_presc + 1'b1;

            if (w_inc)
                r_bright <= r_bright + 1'b1;
            else if (w_dec)
                r_bright <= r_bright - 1'b1;
        end
    end

    pwm_gen #(
        .PWM_BITS (PWM_BITS),
        .N_LEDS   (N_LEDS)
    ) u_pwm (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (r_bright),
        .o_leds  (o_leds)
    );

    assign o_brightness = r_bright;
    assign o_manual     = r_manual;
    assign o_in_window  = r_inWindow;

endmodule

// File: tb/tb_light_schedule_ctrl.sv
// Self-checking bench for light_schedule_ctrl: a scoreboard queue holds the
// expected (state, brightness, spacing) sequence and a monitor pops it on change.
module tb_light_schedule_ctrl;
    import light_schedule_ctrl_pkg::*;

    localparam int N_LEDS   = 16;
    localparam int PWM_BITS = 4;
    localparam int STEP     = 4;

    typedef struct {
        logic [1:0] st;
        logic [3:0] lvl;
        int         gap;
    } exp_t;

    logic                clk = 1'b0;
    logic                rstN = 1'b1;
    logic [5:0]          hours = 6'd12;
    logic [5:0]          minutes = 6'd0;
    logic                override = 1'b0;
    logic                manualOn = 1'b0;
    logic [N_LEDS-1:0]   leds;
    logic [PWM_BITS-1:0] bright;
    logic [1:0]          state;
    logic                manual;
    logic                inWindow;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   lastChange = 0;
    bit   monEn = 1'b0;
    logic [5:0] prevPair = '0;
    exp_t sbQ[$];

    light_schedule_ctrl #(
        .N_LEDS        (N_LEDS),
        .PWM_BITS      (PWM_BITS),
        .FADE_STEP_CYC (STEP),
        .ON_HOUR       (18),
        .ON_MIN        (0),
        .OFF_HOUR      (6),
        .OFF_MIN       (0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_hours      (hours),
        .i_minutes    (minutes),
        .i_override   (override),
        .i_manual_on  (manualOn),
        .o_leds       (leds),
        .o_brightness (bright),
        .o_state      (state),
        .o_manual     (manual),
        .o_in_window  (inWindow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Every change of {state, brightness} must match the next queued entry.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (monEn && ({state, bright} != prevPair)) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb_extra", 32'({state, bright}), 32'(prevPair));
            end else begin
                e = sbQ.pop_front();
                checkOutput("sb_pair", 32'({state, bright}), 32'({e.st, e.lvl}));
                if (e.gap != 0)
                    checkOutput("sb_gap", cyc - lastChange, e.gap);
            end
            lastChange = cyc;
        end
        prevPair = {state, bright};
    end

    task automatic applyStimulus(input logic [5:0] h, input logic [5:0] m);
        hours   = h;
        minutes = m;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulseOverride();
        override = 1'b1;
        @(negedge clk);
        override = 1'b0;
    endtask

    task automatic pushExp(input logic [1:0] st, input int lvl, input int gap);
        exp_t e;
        e.st  = st;
        e.lvl = 4'(lvl);
        e.gap = gap;
        sbQ.push_back(e);
    endtask

    task automatic pushFadeIn(input int fromLvl);
        pushExp(LS_FADE_IN, fromLvl, 0);
        for (int l = fromLvl + 1; l <= 15; l++) pushExp(LS_FADE_IN, l, STEP);
        pushExp(LS_ON, 15, 1);
    endtask

    task automatic pushFadeOut(input int fromLvl);
        pushExp(LS_FADE_OUT, fromLvl, 0);
        for (int l = fromLvl - 1; l >= 0; l--) pushExp(LS_FADE_OUT, l, STEP);
        pushExp(LS_OFF, 0, 1);
    endtask

    task automatic waitDrain(input string tag, input int bound);
        for (int i = 0; i < bound && sbQ.size() != 0; i++) @(negedge clk);
        checkOutput(tag, sbQ.size(), 0);
        sbQ.delete();
    endtask

    task automatic waitLevel(input string tag, input logic [3:0] lvl, input int bound);
        for (int i = 0; i < bound && bright != lvl; i++) @(negedge clk);
        checkOutput(tag, bright, lvl);
    endtask

    initial begin
        int errLeds, errWin, errState, ones, uneven, notAllOn;

        // Reset, time held at 12:00 throughout.
        #1 rstN = 1'b0;
        #1;
        checkOutput("rst_leds", leds, 0);
        checkOutput("rst_bright", bright, 0);
        checkOutput("rst_state", state, LS_OFF);
        checkOutput("rst_manual", manual, 0);
        checkOutput("rst_window", inWindow, 0);
        waitCycles(3);
        rstN = 1'b1;
        monEn = 1'b1;
        errLeds = 0; errWin = 0; errState = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (leds != '0) errLeds++;
            if (inWindow) errWin++;
            if (state != LS_OFF) errState++;
        end
        checkOutput("noon_leds_off", errLeds, 0);
        checkOutput("noon_window_closed", errWin, 0);
        checkOutput("noon_state_off", errState, 0);

        // 17:59 -> 18:00: window opens, full fade-in, then ON.
        applyStimulus(6'd17, 6'd59);
        waitCycles(8);
        checkOutput("win_1759", inWindow, 0);
        pushFadeIn(0);
        applyStimulus(6'd18, 6'd0);
        for (int i = 0; i < 4 && !inWindow; i++) @(negedge clk);
        checkOutput("win_rise_4clk", inWindow, 1);
        waitDrain("fadein_drain", 120);
        notAllOn = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (leds != '1) notAllOn++;
        end
        checkOutput("on_leds_full", notAllOn, 0);
        checkOutput("on_state", state, LS_ON);

        // Midnight wrap keeps the window; 06:00 closes it.
        applyStimulus(6'd23, 6'd59);
        waitCycles(8);
        applyStimulus(6'd0, 6'd0);
        waitCycles(8);
        checkOutput("midnight_window", inWindow, 1);
        checkOutput("midnight_state", state, LS_ON);
        applyStimulus(6'd5, 6'd59);
        waitCycles(8);
        checkOutput("0559_window", inWindow, 1);
        pushFadeOut(15);
        applyStimulus(6'd6, 6'd0);
        waitDrain("fadeout_drain", 120);
        checkOutput("0600_window", inWindow, 0);
        checkOutput("0600_bright", bright, 0);

        // Reversal: the window drop is issued at level 6 so that, after the
        // 4-clock sync latency, it lands while the level sits at 7.
        pushExp(LS_FADE_IN, 0, 0);
        for (int l = 1; l <= 6; l++) pushExp(LS_FADE_IN, l, STEP);
        applyStimulus(6'd18, 6'd0);
        waitLevel("rev_reach6", 4'd6, 120);
        pushExp(LS_FADE_IN, 7, STEP);
        pushExp(LS_FADE_OUT, 7, 1);
        for (int l = 6; l >= 0; l--) pushExp(LS_FADE_OUT, l, STEP);
        pushExp(LS_OFF, 0, 1);
        applyStimulus(6'd12, 6'd0);
        waitDrain("reversal_drain", 120);

        // Manual override on at 12:00, then back to schedule.
        manualOn = 1'b1;
        pushFadeIn(0);
        pulseOverride();
        checkOutput("ovr_manual_on", manual, 1);
        waitDrain("ovr_fadein_drain", 120);
        pushFadeOut(15);
        pulseOverride();
        checkOutput("ovr_manual_off", manual, 0);
        waitDrain("ovr_fadeout_drain", 120);

        // Invalid samples must be discarded.
        applyStimulus(6'd25, 6'd0);
        waitCycles(12);
        checkOutput("bad_hour_window", inWindow, 0);
        checkOutput("bad_hour_state", state, LS_OFF);
        applyStimulus(6'd3, 6'd60);
        waitCycles(12);
        checkOutput("bad_min_window", inWindow, 0);
        checkOutput("bad_min_state", state, LS_OFF);
        applyStimulus(6'd12, 6'd0);
        waitCycles(8);

        // Hold level 8 by flipping the manual target faster than a step.
        manualOn = 1'b1;
        pushExp(LS_FADE_IN, 0, 0);
        for (int l = 1; l <= 8; l++) pushExp(LS_FADE_IN, l, STEP);
        pulseOverride();
        waitLevel("duty_reach8", 4'd8, 120);
        monEn = 1'b0;
        sbQ.delete();
        ones = 0; uneven = 0;
        for (int i = 0; i < 36; i++) begin
            if (i % 2 == 0) manualOn = ~manualOn;
            @(negedge clk);
            if (i >= 4) begin
                if (leds[0]) ones++;
                if (leds != '0 && leds != '1) uneven++;
            end
        end
        checkOutput("duty_8_of_16", ones, 16);
        checkOutput("duty_bits_equal", uneven, 0);
        checkOutput("duty_level_held", bright, 8);

        // Asynchronous reset in the middle of a fade.
        manualOn = 1'b1;
        waitCycles(6);
        checkOutput("pre_reset_fading", state, LS_FADE_IN);
        #3 rstN = 1'b0;
        #1;
        checkOutput("async_leds", leds, 0);
        checkOutput("async_bright", bright, 0);
        checkOutput("async_state", state, LS_OFF);
        checkOutput("async_manual", manual, 0);
        checkOutput("async_window", inWindow, 0);
        waitCycles(2);
        rstN = 1'b1;
        waitCycles(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
